vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster engine: pixel-clock prescaler, horizontal/vertical counters, sync/blank decode
//  and a one-stage colour pipeline that blanks and aligns colour with sync. Replaces the fixed
//  divider + controller pair; the colour source computes rgb_in from hcount/vcount one pixel ahead.
// PARAMETERS
//  CLK_DIV   2    clk cycles per pixel (>=1); 2 gives 25 MHz from 50 MHz
//  H_ACTIVE  640  visible pixels per line;  H_FP 16, H_SYNC 96, H_BP 48 (porch/sync widths in pixels)
//  V_ACTIVE  480  visible lines per frame;  V_FP 10, V_SYNC 2,  V_BP 33 (porch/sync widths in lines)
//  H_POL     0    hsync active level;  V_POL 0  vsync active level
//  CW        10   hcount/vcount width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-low
//  rgb_in       in   8   colour for pixel (hcount,vcount): [7:5] r, [4:2] g, [1:0] b
//  irq_line     in   CW  scanline-interrupt compare value
//  irq_ack      in   1   clears irq
//  pix_en       out  1   one-clk pixel strobe
//  hcount       out  CW  current pixel column (0..H_TOTAL-1)
//  vcount       out  CW  current line (0..V_TOTAL-1)
//  hsync,vsync  out  1   sync outputs, aligned with r/g/b
//  bright       out  1   active-video flag, aligned with r/g/b
//  r,g,b        out  3,3,2  blanked colour
//  frame_start  out  1   one-clk pulse on the pix_en where hcount,vcount wrap to 0,0
//  irq          out  1   sticky scanline interrupt
// BEHAVIOUR
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
//  - Prescaler counts 0..CLK_DIV-1; pix_en=1 when it equals CLK_DIV-1. CLK_DIV=1: pix_en constantly 1.
//  - On pix_en: hcount==H_TOTAL-1 -> 0 and vcount advances, else hcount+1; vcount==V_TOTAL-1 -> 0.
//  - Stage 1 (on pix_en): hs_raw = hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1];
//    vs_raw = vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; act = hcount<H_ACTIVE && vcount<V_ACTIVE.
//    Registers: hsync<=hs_raw?H_POL:~H_POL; vsync likewise with V_POL; bright<=act; {r,g,b}<=act?rgb_in:0.
//    Latency: outputs describe the pixel that hcount/vcount held one pixel earlier; all four change together.
//  - Outputs hold between pix_en strobes.
//  - frame_start registered: 1 for exactly one clk after the edge where counters wrap to (0,0).
//  - Reset (any time, mid-line included): prescaler, hcount, vcount=0; pix_en=0; hsync=~H_POL; vsync=~V_POL;
//    bright=0; r,g,b=0; frame_start=0; irq=0. First pix_en is CLK_DIV clks after rst deasserts.
// CONFIGURATION
//  SCANLINE_IRQ_EN defined: on pix_en with hcount==H_ACTIVE-1 and vcount==irq_line, irq sets to 1
//   and stays until irq_ack sampled high; set and ack in the same clk -> irq=1 (set wins).
//   irq_line>=V_TOTAL never fires.
//  SCANLINE_IRQ_EN undefined: irq tied 0; irq_line, irq_ack ports kept but ignored.
// STRUCTURE
//  - Package vga_timing_pkg: default 640x480@60 timing constants, H_TOTAL/V_TOTAL localparam functions,
//    colour-field width constants (R_W=3, G_W=3, B_W=2).
//  - Sub-module vga_axis_counter (params TOTAL, CW; ports clk, rst, en, count, wrap): instanced for H
//    (en=pix_en) and V (en=pix_en & h wrap).
//  - Sync/blank decode, colour register, frame_start and irq logic in this module.
// TESTING
//  1 Defaults, reset then run 2 frames -> pix_en every 2nd clk; hcount period 800 pix; vcount period 525
//    lines; frame_start pulses exactly 800*525*2=840000 clks apart.
//  2 Defaults -> hsync low for 96 pix from registered hcount 657; vsync low for 2 lines starting the
//    pixel after vcount enters 490; bright high 640x480 per frame.
//  3 rgb_in=8'hE3 constant -> r=7,g=0,b=3 only when bright=1; all 0 in porches and sync.
//  4 CLK_DIV=1, H_ACTIVE=4,H_FP=1,H_SYNC=2,H_BP=1, V_ACTIVE=3,V_FP=1,V_SYNC=1,V_BP=1, H_POL=V_POL=1
//    -> hsync high 2 pix per 8-pix line, vsync high 1 line per 6-line frame, frame period 48 clks.
//  5 Assert rst mid-line (hcount=300,vcount=200) -> all outputs reset values async; restart at (0,0).
//  6 SCANLINE_IRQ_EN, irq_line=100 -> irq rises at hcount 639 of line 100, held; irq_ack pulse clears;
//    ack coincident with next-frame set leaves irq=1. Undefined macro -> irq stays 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the VGA raster engine: 640x480@60 defaults,
// colour-field widths and the axis-total helper.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CW       = 10;

  localparam int R_W   = 3;
  localparam int G_W   = 3;
  localparam int B_W   = 2;
  localparam int RGB_W = R_W + G_W + B_W;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video output bundle: sync, blanking flag and blanked colour, all aligned
// to the same pixel.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic           hsync;
  logic           vsync;
  logic           bright;
  logic [R_W-1:0] r;
  logic [G_W-1:0] g;
  logic [B_W-1:0] b;

  modport master (output hsync, vsync, bright, r, g, b);
  modport slave  (input  hsync, vsync, bright, r, g, b);

endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping raster axis counter (0..TOTAL-1); wrap flags the terminal count.
module vga_axis_counter #(
  parameter int TOTAL = 800,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= wrap ? '0 : count_reg + 1'b1;
    end
  end

  assign wrap  = (count_reg == LAST);
  assign count = count_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: prescaler, H/V counters, sync/blank decode and
// a one-pixel colour stage. Scanline interrupt built only with SCANLINE_IRQ_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = DEF_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RGB_W-1:0] rgb_in,
  input  logic [CW-1:0]    irq_line,
  input  logic             irq_ack,
  output logic             pix_en,
  output logic [CW-1:0]    hcount,
  output logic [CW-1:0]    vcount,
  vga_timing_gen_if.master vid,
  output logic             frame_start,
  output logic             irq
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_LAST_ACT = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [PW-1:0]    pre_reg;
  logic             pix_en_reg;
  logic             h_wrap, v_wrap;
  logic             hs_next, vs_next, act_next;
  logic [RGB_W-1:0] rgb_next, rgb_reg;
  logic             hsync_reg, vsync_reg, bright_reg, frame_start_reg, irq_reg;

  // pix_en is registered so it is low out of reset and first rises CLK_DIV clks later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_reg    <= '0;
      pix_en_reg <= 1'b0;
    end else begin
      pre_reg    <= (pre_reg == PRE_LAST) ? '0 : pre_reg + 1'b1;
      pix_en_reg <= (pre_reg == PRE_LAST);
    end
  end

  vga_axis_counter #(.TOTAL(H_TOTAL), .CW(CW)) u_hcnt (
    .clk(clk), .rst(rst), .en(pix_en_reg), .count(hcount), .wrap(h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .CW(CW)) u_vcnt (
    .clk(clk), .rst(rst), .en(pix_en_reg & h_wrap), .count(vcount), .wrap(v_wrap)
  );

  always_comb begin
    act_next = (hcount < H_ACT) && (vcount < V_ACT);
    hs_next  = ((hcount >= HS_FIRST) && (hcount <= HS_LAST)) ? H_POL : ~H_POL;
    vs_next  = ((vcount >= VS_FIRST) && (vcount <= VS_LAST)) ? V_POL : ~V_POL;
  end

  genvar gi;
  generate
    for (gi = 0; gi < RGB_W; gi++) begin : g_blank
      assign rgb_next[gi] = rgb_in[gi] & act_next;
    end
  endgenerate

  // Colour, sync and blank all capture the same pixel so they stay aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_reg       <= ~H_POL;
      vsync_reg       <= ~V_POL;
      bright_reg      <= 1'b0;
      rgb_reg         <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= pix_en_reg & h_wrap & v_wrap;
      if (pix_en_reg) begin
        hsync_reg  <= hs_next;
        vsync_reg  <= vs_next;
        bright_reg <= act_next;
        rgb_reg    <= rgb_next;
      end
    end
  end

`ifdef SCANLINE_IRQ_EN
  logic irq_set;
  assign irq_set = pix_en_reg && (hcount == H_LAST_ACT) && (vcount == irq_line);

  // A new set outranks an ack arriving in the same clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_reg <= 1'b0;
    end else if (irq_set) begin
      irq_reg <= 1'b1;
    end else if (irq_ack) begin
      irq_reg <= 1'b0;
    end
  end
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{irq_line, irq_ack};
  assign irq_reg = 1'b0;
`endif

  assign pix_en      = pix_en_reg;
  assign frame_start = frame_start_reg;
  assign irq         = irq_reg;
  assign vid.hsync   = hsync_reg;
  assign vid.vsync   = vsync_reg;
  assign vid.bright  = bright_reg;
  assign vid.r       = rgb_reg[RGB_W-1 -: R_W];
  assign vid.g       = rgb_reg[B_W +: G_W];
  assign vid.b       = rgb_reg[0 +: B_W];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-geometry instances checked every clock
// against a raster model computed from the strobe count since reset.
module tb_vga_timing_gen;

  // Instance A: divided pixel clock, active-low syncs, 16x10 raster.
  localparam int DA = 2;
  localparam int HA_A = 8, HF_A = 2, HS_A = 3, HB_A = 3;
  localparam int VA_A = 5, VF_A = 1, VS_A = 2, VB_A = 2;
  localparam int T_A  = (HA_A + HF_A + HS_A + HB_A) * (VA_A + VF_A + VS_A + VB_A);
  // Instance B: undivided, active-high syncs, 8x6 raster.
  localparam int DB = 1;
  localparam int HA_B = 4, HF_B = 1, HS_B = 2, HB_B = 1;
  localparam int VA_B = 3, VF_B = 1, VS_B = 1, VB_B = 1;
  localparam int T_B  = (HA_B + HF_B + HS_B + HB_B) * (VA_B + VF_B + VS_B + VB_B);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rgb_in = 8'h00;
  logic [4:0] irq_line_a = 5'd31;
  logic [2:0] irq_line_b = 3'd7;
  logic       irq_ack = 1'b0;

  logic       pix_en_a, fs_a, irq_a, pix_en_b, fs_b, irq_b;
  logic [4:0] hcount_a, vcount_a;
  logic [2:0] hcount_b, vcount_b;

  vga_timing_gen_if vid_a ();
  vga_timing_gen_if vid_b ();

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(DA), .H_ACTIVE(HA_A), .H_FP(HF_A), .H_SYNC(HS_A), .H_BP(HB_A),
    .V_ACTIVE(VA_A), .V_FP(VF_A), .V_SYNC(VS_A), .V_BP(VB_A),
    .H_POL(1'b0), .V_POL(1'b0), .CW(5)
  ) dut_a (
    .clk(clk), .rst(rst), .rgb_in(rgb_in), .irq_line(irq_line_a), .irq_ack(irq_ack),
    .pix_en(pix_en_a), .hcount(hcount_a), .vcount(vcount_a), .vid(vid_a.master),
    .frame_start(fs_a), .irq(irq_a)
  );

  vga_timing_gen #(
    .CLK_DIV(DB), .H_ACTIVE(HA_B), .H_FP(HF_B), .H_SYNC(HS_B), .H_BP(HB_B),
    .V_ACTIVE(VA_B), .V_FP(VF_B), .V_SYNC(VS_B), .V_BP(VB_B),
    .H_POL(1'b1), .V_POL(1'b1), .CW(3)
  ) dut_b (
    .clk(clk), .rst(rst), .rgb_in(rgb_in), .irq_line(irq_line_b), .irq_ack(irq_ack),
    .pix_en(pix_en_b), .hcount(hcount_b), .vcount(vcount_b), .vid(vid_b.master),
    .frame_start(fs_b), .irq(irq_b)
  );

  logic [23:0] obs_a;
  logic [19:0] obs_b;
  assign obs_a = {pix_en_a, hcount_a, vcount_a, vid_a.hsync, vid_a.vsync, vid_a.bright,
                  vid_a.r, vid_a.g, vid_a.b, fs_a, irq_a};
  assign obs_b = {pix_en_b, hcount_b, vcount_b, vid_b.hsync, vid_b.vsync, vid_b.bright,
                  vid_b.r, vid_b.g, vid_b.b, fs_b, irq_b};

  int checks = 0;
  int failures = 0;
  int e = 0;  // posedges since reset release

  typedef struct {
    bit pe; int h; int v; bit hsy; bit vsy; bit br; bit fs; bit strobe; int qh; int qv;
  } exp_t;

  // Expected state after edge ed: k strobes consumed, counters at pixel k,
  // outputs describe pixel k-1 (the one just processed).
  function automatic exp_t model(int ed, int d, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb, bit hp, bit vp);
    exp_t m;
    int ht = ha + hf + hsw + hb;
    int t  = ht * (va + vf + vsw + vb);
    int k  = (ed < 1) ? 0 : (ed - 1) / d;
    int kp = (ed < 2) ? 0 : (ed - 2) / d;
    int p  = k % t;
    int q;
    m.strobe = (k != kp);
    m.pe  = (ed >= d) && (ed % d == 0);
    m.h   = p % ht;
    m.v   = p / ht;
    m.hsy = ~hp; m.vsy = ~vp; m.br = 1'b0; m.fs = 1'b0; m.qh = -1; m.qv = -1;
    if (k > 0) begin
      q    = (k - 1) % t;
      m.qh = q % ht;
      m.qv = q / ht;
      m.hsy = (m.qh >= ha + hf && m.qh < ha + hf + hsw) ? hp : ~hp;
      m.vsy = (m.qv >= va + vf && m.qv < va + vf + vsw) ? vp : ~vp;
      m.br  = (m.qh < ha) && (m.qv < va);
      m.fs  = m.strobe && (p == 0);
    end
    return m;
  endfunction

  function automatic exp_t model_a(int ed);
    return model(ed, DA, HA_A, HF_A, HS_A, HB_A, VA_A, VF_A, VS_A, VB_A, 1'b0, 1'b0);
  endfunction

  function automatic exp_t model_b(int ed);
    return model(ed, DB, HA_B, HF_B, HS_B, HB_B, VA_B, VF_B, VS_B, VB_B, 1'b1, 1'b1);
  endfunction

  function automatic logic [23:0] vec_a(exp_t x, logic [7:0] rgb, bit irqv);
    return {x.pe, 5'(x.h), 5'(x.v), x.hsy, x.vsy, x.br, (x.br ? rgb : 8'h00), x.fs, irqv};
  endfunction

  function automatic logic [19:0] vec_b(exp_t x, logic [7:0] rgb, bit irqv);
    return {x.pe, 3'(x.h), 3'(x.v), x.hsy, x.vsy, x.br, (x.br ? rgb : 8'h00), x.fs, irqv};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    e = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== vec_a(model_a(0), 8'h00, 1'b0)) begin
        failures++;
        $display("FAIL reset_a cyc=%0d got=%h exp=%h", i, obs_a, vec_a(model_a(0), 8'h00, 1'b0));
      end
      checks++;
      if (obs_b !== vec_b(model_b(0), 8'h00, 1'b0)) begin
        failures++;
        $display("FAIL reset_b cyc=%0d got=%h exp=%h", i, obs_b, vec_b(model_b(0), 8'h00, 1'b0));
      end
    end
    rst = 1'b1;
    e = 0;
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_raster(int ncyc);
    logic [7:0] last_a = 8'h00, last_b = 8'h00;
    int fs_prev_a = -1, fs_prev_b = -1;
    exp_t ea, eb;
    apply_reset();
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); e++;
      @(negedge clk);
      ea = model_a(e); eb = model_b(e);
      if (ea.strobe) last_a = rgb_in;
      if (eb.strobe) last_b = rgb_in;
      checks++;
      if (obs_a !== vec_a(ea, last_a, 1'b0)) begin
        failures++;
        $display("FAIL raster_a e=%0d got=%h exp=%h", e, obs_a, vec_a(ea, last_a, 1'b0));
      end
      checks++;
      if (obs_b !== vec_b(eb, last_b, 1'b0)) begin
        failures++;
        $display("FAIL raster_b e=%0d got=%h exp=%h", e, obs_b, vec_b(eb, last_b, 1'b0));
      end
      if (fs_a === 1'b1) begin
        if (fs_prev_a >= 0) begin
          checks++;
          if (e - fs_prev_a != DA * T_A) begin
            failures++;
            $display("FAIL frame_period_a got=%0d exp=%0d", e - fs_prev_a, DA * T_A);
          end
        end
        fs_prev_a = e;
      end
      if (fs_b === 1'b1) begin
        if (fs_prev_b >= 0) begin
          checks++;
          if (e - fs_prev_b != DB * T_B) begin
            failures++;
            $display("FAIL frame_period_b got=%0d exp=%0d", e - fs_prev_b, DB * T_B);
          end
        end
        fs_prev_b = e;
      end
      rgb_in = 8'($urandom);
    end
    $display("test_raster done checks=%0d", checks);
  endtask

  task automatic test_colour();
    exp_t ea;
    rgb_in = 8'hE3;
    apply_reset();
    for (int i = 0; i < DA * T_A + 8; i++) begin
      @(posedge clk); e++;
      @(negedge clk);
      ea = model_a(e);
      checks++;
      if ({vid_a.bright, vid_a.r, vid_a.g, vid_a.b} !== (ea.br ? 9'h1_E3 : 9'h0_00)) begin
        failures++;
        $display("FAIL colour_e3 e=%0d got=%h exp=%h", e,
                 {vid_a.bright, vid_a.r, vid_a.g, vid_a.b}, (ea.br ? 9'h1_E3 : 9'h0_00));
      end
    end
    $display("test_colour done checks=%0d", checks);
  endtask

  task automatic test_mid_reset();
    logic [7:0] last_a = 8'h00;
    exp_t ea;
    int run = int'($urandom_range(60, 200));
    apply_reset();
    for (int i = 0; i < run + 40; i++) begin
      if (i == run) begin
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs_a !== vec_a(model_a(0), 8'h00, 1'b0)) begin
          failures++;
          $display("FAIL async_reset_a got=%h exp=%h", obs_a, vec_a(model_a(0), 8'h00, 1'b0));
        end
        checks++;
        if (obs_b !== vec_b(model_b(0), 8'h00, 1'b0)) begin
          failures++;
          $display("FAIL async_reset_b got=%h exp=%h", obs_b, vec_b(model_b(0), 8'h00, 1'b0));
        end
        @(negedge clk);
        rst = 1'b1;
        e = 0;
      end
      @(posedge clk); e++;
      @(negedge clk);
      ea = model_a(e);
      if (ea.strobe) last_a = rgb_in;
      checks++;
      if (obs_a !== vec_a(ea, last_a, 1'b0)) begin
        failures++;
        $display("FAIL mid_reset_a e=%0d got=%h exp=%h", e, obs_a, vec_a(ea, last_a, 1'b0));
      end
      rgb_in = 8'($urandom);
    end
    $display("test_mid_reset done checks=%0d", checks);
  endtask

  task automatic test_irq();
    logic [7:0] last_a = 8'h00, last_b = 8'h00;
    bit   irq_exp = 1'b0;
    bit   set_cond;
    int   fires = 0, hold = 0;
    exp_t ea, eb, nx;
    irq_line_a = 5'd3;
    apply_reset();
    for (int i = 0; i < 2 * DA * T_A + 20; i++) begin
      @(posedge clk); e++;
      @(negedge clk);
      ea = model_a(e); eb = model_b(e);
      if (ea.strobe) last_a = rgb_in;
      if (eb.strobe) last_b = rgb_in;
      set_cond = ea.strobe && (ea.qh == HA_A - 1) && (ea.qv == int'(irq_line_a));
`ifdef SCANLINE_IRQ_EN
      if (set_cond) irq_exp = 1'b1;
      else if (irq_ack) irq_exp = 1'b0;
`endif
      if (set_cond) fires++;
      if (fires >= 1) hold++;
      checks++;
      if (obs_a !== vec_a(ea, last_a, irq_exp)) begin
        failures++;
        $display("FAIL irq_a e=%0d got=%h exp=%h", e, obs_a, vec_a(ea, last_a, irq_exp));
      end
      checks++;
      if (obs_b !== vec_b(eb, last_b, 1'b0)) begin
        failures++;
        $display("FAIL irq_b_never e=%0d got=%h exp=%h", e, obs_b, vec_b(eb, last_b, 1'b0));
      end
      // One lone ack while irq is held, then an ack coinciding with the next set.
      nx = model_a(e + 1);
      irq_ack = (fires == 1) && ((hold == 6) ||
                (nx.strobe && nx.qh == HA_A - 1 && nx.qv == int'(irq_line_a)));
      rgb_in = 8'($urandom);
    end
    irq_ack = 1'b0;
    irq_line_a = 5'd31;
    $display("test_irq done checks=%0d fires=%0d", checks, fires);
  endtask

  initial begin
    test_reset();
    test_raster(2 * DA * T_A + 20);
    test_colour();
    test_mid_reset();
    test_irq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
